// File: rtl/instruc_stream_router_pkg.sv
//==============================================================================
// instruc_stream_router_pkg: shared widths, header layout and parser states
// Rev 1.0
//==============================================================================
`default_nettype none

package instruc_stream_router_pkg;

    localparam int WORD_WIDTH    = 32;
    localparam int OPCODE_WIDTH  = 8;
    localparam int BODYLEN_WIDTH = 24;
    localparam int HEADER_WIDTH  = OPCODE_WIDTH + BODYLEN_WIDTH;
    localparam int TOTAL_OPCODES = 13;
    localparam int CNT_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GET_HEADER = 2'd1,
        GET_BODY   = 2'd2
    } decoder_statetype;

    typedef logic [OPCODE_WIDTH-1:0]  opcodetype;
    typedef logic [BODYLEN_WIDTH-1:0] bodylentype;

    typedef struct packed {
        opcodetype  opcode;
        bodylentype bodylen;
    } instruc_header_t;

endpackage

`default_nettype wire

// File: rtl/instruc_out_reg.sv
//==============================================================================
// instruc_out_reg: single-entry valid/ready register with one-hot channel valid
// Rev 1.0
//==============================================================================
`default_nettype none

module instruc_out_reg #(
    parameter int WORD_WIDTH = 32,
    parameter int N_CHANNELS = 13
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic [WORD_WIDTH-1:0] data_i,
    input  logic [N_CHANNELS-1:0] chan_i,
    input  logic                  last_i,
    input  logic [N_CHANNELS-1:0] ready_i,
    output logic [WORD_WIDTH-1:0] data_o,
    output logic [N_CHANNELS-1:0] valid_o,
    output logic                  last_o,
    output logic                  release_o
);

    logic [WORD_WIDTH-1:0] data_q;
    logic [N_CHANNELS-1:0] valid_q;
    logic                  last_q;

    // Only the ready of the channel that owns the held word can release it.
    assign release_o = |(valid_q & ready_i);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_q  <= '0;
            valid_q <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            valid_q <= chan_i;
            last_q  <= last_i;
        end else if (release_o) begin
            valid_q <= '0;
            last_q  <= 1'b0;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign last_o  = last_q;

endmodule

`default_nettype wire

// File: rtl/instruc_stream_router.sv
//==============================================================================
// instruc_stream_router: parses host headers and routes bodies to per-opcode channels
// Rev 1.0
//==============================================================================
`default_nettype none

module instruc_stream_router #(
    parameter int WORD_WIDTH    = instruc_stream_router_pkg::WORD_WIDTH,
    parameter int OPCODE_WIDTH  = instruc_stream_router_pkg::OPCODE_WIDTH,
    parameter int BODYLEN_WIDTH = instruc_stream_router_pkg::BODYLEN_WIDTH,
    parameter int N_CHANNELS    = instruc_stream_router_pkg::TOTAL_OPCODES,
    parameter int CNT_WIDTH     = instruc_stream_router_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [N_CHANNELS-1:0] out_valid,
    input  logic [N_CHANNELS-1:0] out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err_opcode,
    output logic [CNT_WIDTH-1:0]  hdr_count,
    output logic [CNT_WIDTH-1:0]  err_count
);
    import instruc_stream_router_pkg::*;

    localparam int HEADER_WIDTH = OPCODE_WIDTH + BODYLEN_WIDTH;

    decoder_statetype         state_q, state_d;
    logic [OPCODE_WIDTH-1:0]  opcode_q, opcode_d;
    logic [BODYLEN_WIDTH-1:0] remaining_q, remaining_d;
    logic                     drain_q, drain_d;
    logic                     err_q, err_d;
    logic [CNT_WIDTH-1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [CNT_WIDTH-1:0]     err_cnt_q, err_cnt_d;

    logic [OPCODE_WIDTH-1:0]  hdr_opcode;
    logic [BODYLEN_WIDTH-1:0] hdr_len;
    logic                     hdr_legal;
    logic                     out_full;
    logic                     out_release;
    logic                     accept;
    logic                     load;
    logic                     body_last;
    logic [N_CHANNELS-1:0]    chan_onehot;

    assign hdr_opcode  = in_data[HEADER_WIDTH-1:BODYLEN_WIDTH];
    assign hdr_len     = in_data[BODYLEN_WIDTH-1:0];
    assign hdr_legal   = ({1'b0, hdr_opcode} < (OPCODE_WIDTH+1)'(N_CHANNELS));
    assign body_last   = (remaining_q == BODYLEN_WIDTH'(1));
    assign chan_onehot = N_CHANNELS'(1) << opcode_q;

    // Release uses the held word's own channel, which may belong to the previous instruction.
    assign out_full = |out_valid;
    assign in_ready = resetn & ((state_q != GET_BODY) | drain_q | ~out_full | out_release);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        remaining_d = remaining_q;
        drain_d     = drain_q;
        err_d       = err_q;
        hdr_cnt_d   = hdr_cnt_q;
        err_cnt_d   = err_cnt_q;
        load        = 1'b0;
        case (state_q)
            IDLE, GET_HEADER: begin
                if (accept) begin
                    hdr_cnt_d   = hdr_cnt_q + CNT_WIDTH'(1);
                    opcode_d    = hdr_opcode;
                    remaining_d = hdr_len;
                    drain_d     = ~hdr_legal;
                    if (!hdr_legal) begin
                        err_d = 1'b1;
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                    state_d = (hdr_len == '0) ? IDLE : GET_BODY;
                end else if (state_q == GET_HEADER) begin
                    state_d = IDLE;
                end
            end
            GET_BODY: begin
                if (accept) begin
                    remaining_d = remaining_q - BODYLEN_WIDTH'(1);
                    load        = ~drain_q;
                    // The final word was accepted with in_valid high: expect a header next.
                    if (body_last) begin
                        state_d = GET_HEADER;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            opcode_q    <= '0;
            remaining_q <= '0;
            drain_q     <= 1'b0;
            err_q       <= 1'b0;
            hdr_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            remaining_q <= remaining_d;
            drain_q     <= drain_d;
            err_q       <= err_d;
            hdr_cnt_q   <= hdr_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    instruc_out_reg #(
        .WORD_WIDTH (WORD_WIDTH),
        .N_CHANNELS (N_CHANNELS)
    ) u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load_i    (load),
        .data_i    (in_data),
        .chan_i    (chan_onehot),
        .last_i    (body_last),
        .ready_i   (out_ready),
        .data_o    (out_data),
        .valid_o   (out_valid),
        .last_o    (out_last),
        .release_o (out_release)
    );

    assign busy       = (state_q != IDLE) | out_full;
    assign err_opcode = err_q;
    assign hdr_count  = hdr_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_instruc_stream_router.sv
//==============================================================================
// tb_instruc_stream_router: directed scenarios plus random traffic against a word-level model
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_instruc_stream_router;

    localparam int WW  = 16;
    localparam int NCH = 13;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic [WW-1:0]   in_data;
    logic            in_valid;
    logic            in_ready;
    logic [WW-1:0]   out_data;
    logic [NCH-1:0]  out_valid;
    logic [NCH-1:0]  out_ready;
    logic            out_last;
    logic            busy;
    logic            err_opcode;
    logic [CW-1:0]   hdr_count;
    logic [CW-1:0]   err_count;

    instruc_stream_router #(
        .WORD_WIDTH    (WW),
        .OPCODE_WIDTH  (8),
        .BODYLEN_WIDTH (4),
        .N_CHANNELS    (NCH),
        .CNT_WIDTH     (CW)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .err_opcode (err_opcode),
        .hdr_count  (hdr_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] d;
        int            ch;
        bit            last;
        int            cyc;
    } ent_t;

    // Model: instruction position, one-deep output slot, counters
    logic [WW-1:0] inq[$];
    ent_t          pend[$];
    ent_t          obs[$];
    bit            m_in_body, m_drain, m_after, m_err, m_acc;
    int            m_rem, m_op, m_hdr, m_errc;
    int            n_vec = 0, n_fail = 0, cyc = 0, acc_cnt = 0;
    int            rmode = 0, vprob = 100;
    bit            tog = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_body = 0; m_drain = 0; m_after = 0; m_err = 0; m_acc = 0;
        m_rem = 0; m_op = 0; m_hdr = 0; m_errc = 0;
        pend.delete();
    endtask

    function automatic bit exp_in_ready();
        if (!resetn) return 1'b0;
        return !m_in_body || m_drain || pend.size() == 0 || out_ready[pend[0].ch];
    endfunction

    task automatic model_update();
        bit   acc, rel;
        int   op, len;
        ent_t e;
        if (!resetn) begin
            model_reset();
            return;
        end
        acc     = in_valid && exp_in_ready();
        rel     = pend.size() != 0 && out_ready[pend[0].ch];
        m_after = 0;
        if (rel) void'(pend.pop_front());
        if (acc) begin
            if (!m_in_body) begin
                op    = int'(in_data[11:4]);
                len   = int'(in_data[3:0]);
                m_hdr = (m_hdr + 1) % (1 << CW);
                if (op >= NCH) begin
                    m_err = 1;
                    if (m_errc < (1 << CW) - 1) m_errc++;
                end
                if (len > 0) begin
                    m_in_body = 1; m_rem = len; m_op = op; m_drain = (op >= NCH);
                end
            end else begin
                if (!m_drain) begin
                    e.d = in_data; e.ch = m_op; e.last = (m_rem == 1); e.cyc = 0;
                    pend.push_back(e);
                end
                m_rem--;
                if (m_rem == 0) begin
                    m_in_body = 0; m_after = 1;
                end
            end
        end
        m_acc = acc;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        if (m_acc) begin
            void'(inq.pop_front());
            acc_cnt++;
        end
        case (rmode)
            1: out_ready = NCH'($urandom);
            2: begin out_ready = '1; out_ready[5] = tog; tog = ~tog; end
            default: out_ready = '1;
        endcase
        if (inq.size() != 0 && $urandom_range(99) < vprob) begin
            in_valid = 1'b1; in_data = inq[0];
        end else begin
            in_valid = 1'b0; in_data = WW'($urandom);
        end
    endtask

    task automatic run(input int max);
        int n = 0;
        while ((inq.size() != 0 || m_in_body || pend.size() != 0) && n < max) begin
            step();
            n++;
        end
        step();
        step();
        chk("run_timeout", (n >= max) ? 1 : 0, 0);
    endtask

    task automatic push_hdr(input int op, input int len);
        inq.push_back({4'($urandom), 8'(op), 4'(len)});
    endtask

    // Per-cycle compare of every output against the model
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", out_valid, pend.size() != 0 ? (NCH'(1) << pend[0].ch) : '0);
            if (pend.size() != 0) chk("out_data", out_data, pend[0].d);
            chk("out_last", out_last, pend.size() != 0 ? pend[0].last : 1'b0);
            chk("in_ready", in_ready, exp_in_ready());
            chk("busy", busy, m_in_body || m_after || pend.size() != 0);
            chk("err_opcode", err_opcode, m_err);
            chk("hdr_count", hdr_count, m_hdr);
            chk("err_count", err_count, m_errc);
            if (resetn && |(out_valid & out_ready)) begin
                ent_t e;
                e.d = out_data; e.last = out_last; e.cyc = cyc; e.ch = -1;
                for (int i = 0; i < NCH; i++) if (out_valid[i]) e.ch = i;
                obs.push_back(e);
            end
            cyc++;
        end
    end

    initial begin
        int base, n;
        resetn = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '1;
        model_reset();
        repeat (3) step();
        #5 resetn = 1'b1;

        // Basic route on channel 2
        obs.delete(); rmode = 0; vprob = 100;
        push_hdr(2, 3); inq.push_back(16'hA0A1); inq.push_back(16'hB0B1); inq.push_back(16'hC0C1);
        run(100);
        chk("t1_n", obs.size(), 3);
        chk("t1_d0", obs[0].d, 16'hA0A1);
        chk("t1_d2", obs[2].d, 16'hC0C1);
        chk("t1_ch", obs[1].ch, 2);
        chk("t1_last0", obs[0].last, 0);
        chk("t1_last2", obs[2].last, 1);
        chk("t1_span", obs[2].cyc - obs[0].cyc, 2);
        chk("t1_hdr", hdr_count, 1);

        // Stalls on channel 5
        obs.delete(); rmode = 2; tog = 1'b1;
        push_hdr(5, 4);
        for (int i = 1; i <= 4; i++) inq.push_back(16'h5000 + 16'(i));
        run(100);
        chk("t2_n", obs.size(), 4);
        chk("t2_d1", obs[1].d, 16'h5002);
        chk("t2_d3", obs[3].d, 16'h5004);
        chk("t2_last", obs[3].last, 1);

        // Illegal opcode drained, then legal word on channel 0
        obs.delete(); rmode = 0;
        push_hdr(200, 2); inq.push_back(16'hDEAD); inq.push_back(16'hBEEF);
        push_hdr(0, 1); inq.push_back(16'h0C0C);
        run(100);
        chk("t3_n", obs.size(), 1);
        chk("t3_d", obs[0].d, 16'h0C0C);
        chk("t3_ch", obs[0].ch, 0);
        chk("t3_err", err_opcode, 1);
        chk("t3_errc", err_count, 1);

        // Zero-length header back to back with a one-word body
        obs.delete();
        push_hdr(1, 0); push_hdr(1, 1); inq.push_back(16'h7777);
        run(100);
        chk("t4_n", obs.size(), 1);
        chk("t4_ch", obs[0].ch, 1);
        chk("t4_last", obs[0].last, 1);
        chk("t4_hdr", hdr_count, 6);

        // Reset mid-body
        push_hdr(3, 5);
        for (int i = 0; i < 5; i++) inq.push_back(16'h3300 + 16'(i));
        base = acc_cnt; n = 0;
        while (acc_cnt < base + 3 && n < 50) begin step(); n++; end
        chk("t5_timeout", (n >= 50) ? 1 : 0, 0);
        #2 resetn = 1'b0;
        model_reset(); inq.delete(); in_valid = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_busy", busy, 0);
        chk("t5_hdr", hdr_count, 0);
        chk("t5_inrdy", in_ready, 0);
        step();
        #5 resetn = 1'b1;
        obs.delete();
        push_hdr(4, 1); inq.push_back(16'h4444);
        run(100);
        chk("t5_n", obs.size(), 1);
        chk("t5_ch", obs[0].ch, 4);
        chk("t5_d", obs[0].d, 16'h4444);

        // Counter saturation and wrap (4-bit counters)
        obs.delete();
        for (int i = 0; i < 15; i++) push_hdr(13 + i, 0);
        run(200);
        chk("t6_hdrwrap", hdr_count, 0);
        chk("t6_errsat", err_count, 15);
        push_hdr(255, 1); inq.push_back(16'hFFFF);
        run(100);
        chk("t6_errhold", err_count, 15);
        chk("t6_hdr", hdr_count, 1);
        chk("t6_n", obs.size(), 0);

        // Random traffic with random backpressure, including max body length
        rmode = 1; vprob = 70;
        for (int k = 0; k < 250; k++) begin
            int op, len, r;
            op  = ($urandom_range(99) < 85) ? $urandom_range(NCH - 1) : $urandom_range(255, NCH);
            r   = $urandom_range(9);
            len = (r == 0) ? 0 : (r == 1) ? 15 : $urandom_range(5, 1);
            push_hdr(op, len);
            for (int i = 0; i < len; i++) inq.push_back(WW'($urandom));
        end
        run(30000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
